// File: rtl/adc_multi_chip_align_pack.sv
// rtl/adc_multi_chip_align_pack.sv - multi-chip ADC sample aligner and enabled-channel packer
//
// Each active chip feeds its own skew FIFO. When every active FIFO holds data,
// all of them pop together, and the enabled channels are packed from lane 0 up.
//
// Ports:
//   adc_clk, adc_rst           clock, synchronous active-high reset
//   in_valid  [NUM_CHIPS]      per-chip sample strobe
//   in_data   [NCH*SW]         channel k at [k*SW +: SW], chip c owns CHAN_PER_CHIP channels
//   ch_enable [NCH]            channel enables, latched when leaving IDLE
//   capture_en                 capture request level
//   sync_in                    TDD sync, synchronous to adc_clk
//   ovf_clear                  clears the sticky overflow flag
//   out_valid/out_data/out_count  one packed, aligned sample set per strobe
//   overflow                   sticky skew-FIFO overflow
//   state                      0 IDLE, 1 ARMED, 2 RUN
module adc_multi_chip_align_pack #(
  parameter int NUM_CHIPS     = 2,
  parameter int CHAN_PER_CHIP = 4,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_MODE     = 0,
  localparam int NCH = NUM_CHIPS * CHAN_PER_CHIP,
  localparam int CW  = $clog2(NCH + 1)
) (
  input  logic                        adc_clk,
  input  logic                        adc_rst,
  input  logic [NUM_CHIPS-1:0]        in_valid,
  input  logic [NCH*SAMPLE_WIDTH-1:0] in_data,
  input  logic [NCH-1:0]              ch_enable,
  input  logic                        capture_en,
  input  logic                        sync_in,
  input  logic                        ovf_clear,
  output logic                        out_valid,
  output logic [NCH*SAMPLE_WIDTH-1:0] out_data,
  output logic [CW-1:0]               out_count,
  output logic                        overflow,
  output logic [1:0]                  state
);
  localparam int CPW  = CHAN_PER_CHIP * SAMPLE_WIDTH;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        sync_prev_q, sync_prev_d;
  logic [NCH-1:0]              en_q, en_d;
  logic                        flush_q, flush_d;
  logic                        overflow_q, overflow_d;
  logic                        out_valid_q, out_valid_d;
  logic [NCH*SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]               out_count_q, out_count_d;

  logic [CPW-1:0]  mem_q    [NUM_CHIPS][FIFO_DEPTH];
  logic [CPW-1:0]  mem_d    [NUM_CHIPS][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q [NUM_CHIPS];
  logic [AW-1:0]   wr_ptr_d [NUM_CHIPS];
  logic [AW-1:0]   rd_ptr_q [NUM_CHIPS];
  logic [AW-1:0]   rd_ptr_d [NUM_CHIPS];
  logic [CNTW-1:0] cnt_q    [NUM_CHIPS];
  logic [CNTW-1:0] cnt_d    [NUM_CHIPS];

  logic                 run;
  logic                 leave_idle;
  logic                 pop;
  logic [NUM_CHIPS-1:0] active;
  logic [NUM_CHIPS-1:0] wr_req;
  logic [NUM_CHIPS-1:0] pop_c;
  logic [NUM_CHIPS-1:0] ovf_hit;
  logic [NUM_CHIPS-1:0] wr_ok;
  int                   lane;

  // FSM: state register
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture_en) begin
          state_d = (SYNC_MODE != 0) ? ST_ARMED : ST_RUN;
        end
      end
      ST_ARMED: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end else if (sync_in && !sync_prev_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run        = (state_q == ST_RUN);
    leave_idle = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  end

  // Sync history tracks the real previous cycle, reset or not, so an edge
  // right after reset release is judged on what the line actually did.
  always_comb begin
    sync_prev_d = sync_in;
  end

  always_ff @(posedge adc_clk) begin
    sync_prev_q <= sync_prev_d;
  end

  // Pop decision: all active FIFOs non-empty; the flush cycle after an
  // overflow neither pops nor writes so every chip restarts from empty.
  always_comb begin
    en_d = leave_idle ? ch_enable : en_q;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      active[c] = |en_q[c*CHAN_PER_CHIP +: CHAN_PER_CHIP];
    end
    pop = run && (|active) && !flush_q;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (active[c] && (cnt_q[c] == '0)) begin
        pop = 1'b0;
      end
    end
  end

  // Per-chip skew FIFOs
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      wr_req[c]  = run && active[c] && in_valid[c] && !flush_q;
      pop_c[c]   = pop && active[c];
      // A full FIFO only has room if it pops in the same cycle.
      ovf_hit[c] = wr_req[c] && (cnt_q[c] == CNTW'(FIFO_DEPTH)) && !pop_c[c];
      wr_ok[c]   = wr_req[c] && !ovf_hit[c];
      if (flush_q || !run) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end else begin
        if (wr_ok[c]) begin
          mem_d[c][wr_ptr_q[c]] = in_data[c*CPW +: CPW];
          wr_ptr_d[c]           = wr_ptr_q[c] + AW'(1);
        end
        if (pop_c[c]) begin
          rd_ptr_d[c] = rd_ptr_q[c] + AW'(1);
        end
        cnt_d[c] = cnt_q[c] + CNTW'(wr_ok[c]) - CNTW'(pop_c[c]);
      end
    end
    overflow_d = (overflow_q && !ovf_clear) || (|ovf_hit);
    flush_d    = |ovf_hit;
  end

  // Packing: enabled channels of the popped heads, ascending, from lane 0.
  always_comb begin
    out_valid_d = pop;
    out_data_d  = '0;
    out_count_d = '0;
    lane        = 0;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      for (int j = 0; j < CHAN_PER_CHIP; j++) begin
        out_count_d = out_count_d + CW'(en_q[c*CHAN_PER_CHIP + j]);
        if (pop && en_q[c*CHAN_PER_CHIP + j]) begin
          out_data_d[lane*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            mem_q[c][rd_ptr_q[c]][j*SAMPLE_WIDTH +: SAMPLE_WIDTH];
          lane = lane + 1;
        end
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    mem_q <= mem_d;
    if (adc_rst) begin
      en_q        <= '0;
      flush_q     <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      for (int c = 0; c < NUM_CHIPS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      en_q        <= en_d;
      flush_q     <= flush_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      for (int c = 0; c < NUM_CHIPS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign overflow  = overflow_q;
  assign state     = state_q;

endmodule
